// File: rtl/driver_pkg.sv
// Shared definitions for the driver read-port arbiter.
//   arb_state_e : arbiter FSM states (idle / read outstanding)
//   CNT_W       : width of the saturating event counters and the watchdog
//   sat_inc     : saturating increment for CNT_W-bit counters
package driver_pkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_WAIT = 1'b1
  } arb_state_e;

  localparam int unsigned CNT_W = 16;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker.
//   i_req  : request vector
//   i_last : index of the most recently granted requester
//   o_gnt  : one-hot grant (all zero when no request)
//   o_idx  : index of the granted requester
//   o_any  : at least one request present
// Search starts one past i_last and wraps, so the last winner has lowest priority.
module rr_arbiter #(
  parameter int unsigned N = 2,
  localparam int unsigned IdxW = $clog2(N)
) (
  input  logic [N-1:0]    i_req,
  input  logic [IdxW-1:0] i_last,
  output logic [N-1:0]    o_gnt,
  output logic [IdxW-1:0] o_idx,
  output logic            o_any
);

  int unsigned w_pos;

  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    w_pos = 0;
    for (int unsigned k = 1; k <= N; k++) begin
      w_pos = 32'(i_last) + k;
      if (w_pos >= N) w_pos = w_pos - N;
      if (!o_any && i_req[IdxW'(w_pos)]) begin
        o_any               = 1'b1;
        o_gnt[IdxW'(w_pos)] = 1'b1;
        o_idx               = IdxW'(w_pos);
      end
    end
  end

endmodule

// File: rtl/driver_rd_arbiter.sv
// Shares one memory master read port between NUM_REQ requesters.
// Round-robin grant, single outstanding read, response routed to its owner,
// watchdog aborts a read that receives no response.
// Ports:
//   i_clk, i_rst_n                 clock, async active-low reset
//   i_req_rd / i_req_addr          per-requester level request and flat address
//   o_req_gnt                      one-hot accept pulse
//   o_req_data / o_req_data_val    shared return data, one-hot valid pulse to owner
//   o_req_err                      qualifies data_val: read timed out, data is 0
//   o_master_addr / o_master_rd    address and 1-cycle read strobe to memory
//   i_master_data_in(_val)         memory response
//   o_busy                         read outstanding
//   o_timeout_cnt / o_stray_cnt    saturating counts of aborted reads / responses seen idle
module driver_rd_arbiter
  import driver_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 2,
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic [NUM_REQ-1:0]        i_req_rd,
  input  logic [NUM_REQ*ADDR_W-1:0] i_req_addr,
  output logic [NUM_REQ-1:0]        o_req_gnt,
  output logic [DATA_W-1:0]         o_req_data,
  output logic [NUM_REQ-1:0]        o_req_data_val,
  output logic                      o_req_err,
  output logic [ADDR_W-1:0]         o_master_addr,
  output logic                      o_master_rd,
  input  logic [DATA_W-1:0]         i_master_data_in,
  input  logic                      i_master_data_in_val,
  output logic                      o_busy,
  output logic [CNT_W-1:0]          o_timeout_cnt,
  output logic [CNT_W-1:0]          o_stray_cnt
);

  localparam int unsigned IdxW = $clog2(NUM_REQ);
  localparam logic [CNT_W-1:0] WdogLast = CNT_W'(TIMEOUT_CYCLES - 1);

  arb_state_e          r_state;
  logic [IdxW-1:0]     r_rr_last;
  logic [IdxW-1:0]     r_owner;
  logic [CNT_W-1:0]    r_wdog;
  logic [NUM_REQ-1:0]  r_gnt;
  logic                r_mrd;
  logic [ADDR_W-1:0]   r_maddr;
  logic [DATA_W-1:0]   r_data;
  logic [NUM_REQ-1:0]  r_val;
  logic                r_err;
  logic [CNT_W-1:0]    r_tcnt;
  logic [CNT_W-1:0]    r_scnt;

  logic [NUM_REQ-1:0]  w_gnt;
  logic [IdxW-1:0]     w_idx;
  logic                w_any;
  logic [ADDR_W-1:0]   w_addr;
  logic [NUM_REQ-1:0]  w_owner_oh;

  rr_arbiter #(
    .N (NUM_REQ)
  ) u_rr (
    .i_req  (i_req_rd),
    .i_last (r_rr_last),
    .o_gnt  (w_gnt),
    .o_idx  (w_idx),
    .o_any  (w_any)
  );

  always_comb begin
    w_addr     = i_req_addr[32'(w_idx)*ADDR_W +: ADDR_W];
    w_owner_oh = NUM_REQ'(1) << r_owner;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= ARB_IDLE;
      r_rr_last <= IdxW'(NUM_REQ - 1);
      r_owner   <= '0;
      r_wdog    <= '0;
      r_gnt     <= '0;
      r_mrd     <= 1'b0;
      r_maddr   <= '0;
      r_data    <= '0;
      r_val     <= '0;
      r_err     <= 1'b0;
      r_tcnt    <= '0;
      r_scnt    <= '0;
    end else begin
      // Strobes default low so every pulse lasts exactly one cycle.
      r_gnt <= '0;
      r_mrd <= 1'b0;
      r_val <= '0;
      r_err <= 1'b0;
      case (r_state)
        ARB_IDLE: begin
          if (i_master_data_in_val) r_scnt <= sat_inc(r_scnt);
          if (w_any) begin
            r_gnt     <= w_gnt;
            r_mrd     <= 1'b1;
            r_maddr   <= w_addr;
            r_owner   <= w_idx;
            r_rr_last <= w_idx;
            r_wdog    <= '0;
            r_state   <= ARB_WAIT;
          end
        end
        ARB_WAIT: begin
          // A response on the timeout cycle still wins over the abort.
          if (i_master_data_in_val) begin
            r_data  <= i_master_data_in;
            r_val   <= w_owner_oh;
            r_state <= ARB_IDLE;
          end else if (r_wdog == WdogLast) begin
            r_data  <= '0;
            r_val   <= w_owner_oh;
            r_err   <= 1'b1;
            r_tcnt  <= sat_inc(r_tcnt);
            r_state <= ARB_IDLE;
          end else begin
            r_wdog <= r_wdog + 1'b1;
          end
        end
        default: r_state <= ARB_IDLE;
      endcase
    end
  end

  always_comb begin
    o_req_gnt      = r_gnt;
    o_req_data     = r_data;
    o_req_data_val = r_val;
    o_req_err      = r_err;
    o_master_addr  = r_maddr;
    o_master_rd    = r_mrd;
    o_busy         = (r_state == ARB_WAIT);
    o_timeout_cnt  = r_tcnt;
    o_stray_cnt    = r_scnt;
  end

endmodule

// File: tb/tb_driver_rd_arbiter.sv
module tb_driver_rd_arbiter;

  localparam int NR = 2;
  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_rd;
  logic [63:0] req_addr;
  logic [1:0]  gnt;
  logic [31:0] data;
  logic [1:0]  val;
  logic        err;
  logic [31:0] maddr;
  logic        mrd;
  logic [31:0] mdi;
  logic        mdv;
  logic        busy;
  logic [15:0] tcnt;
  logic [15:0] scnt;

  int n_checks = 0;
  int n_err    = 0;

  driver_rd_arbiter #(
    .NUM_REQ        (NR),
    .ADDR_W         (32),
    .DATA_W         (32),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .i_clk                (clk),
    .i_rst_n              (rst_n),
    .i_req_rd             (req_rd),
    .i_req_addr           (req_addr),
    .o_req_gnt            (gnt),
    .o_req_data           (data),
    .o_req_data_val       (val),
    .o_req_err            (err),
    .o_master_addr        (maddr),
    .o_master_rd          (mrd),
    .i_master_data_in     (mdi),
    .i_master_data_in_val (mdv),
    .o_busy               (busy),
    .o_timeout_cnt        (tcnt),
    .o_stray_cnt          (scnt)
  );

  always #5 clk = ~clk;

  // Reference model: owner index (-1 = none), cycles spent waiting, last winner.
  int          m_owner;
  int          m_waited;
  int          m_last;
  logic [1:0]  e_gnt, e_val;
  logic        e_mrd, e_err;
  logic [31:0] e_data, e_maddr;
  logic [15:0] e_tcnt, e_scnt;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%h expected=%h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_owner = -1; m_waited = 0; m_last = NR - 1;
    e_gnt = 0; e_val = 0; e_mrd = 0; e_err = 0;
    e_data = 0; e_maddr = 0; e_tcnt = 0; e_scnt = 0;
  endtask

  task automatic model_edge();
    bit found;
    int c;
    if (!rst_n) begin
      model_reset();
      return;
    end
    e_gnt = 0; e_mrd = 0; e_val = 0; e_err = 0;
    if (m_owner < 0) begin
      if (mdv && e_scnt != 16'hFFFF) e_scnt = e_scnt + 1;
      found = 0;
      for (int k = 1; k <= NR; k++) begin
        c = (m_last + k) % NR;
        if (!found && req_rd[c]) begin
          found    = 1;
          e_gnt    = 2'(1 << c);
          e_mrd    = 1;
          e_maddr  = req_addr[c*32 +: 32];
          m_owner  = c;
          m_last   = c;
          m_waited = 0;
        end
      end
    end else if (mdv) begin
      e_val   = 2'(1 << m_owner);
      e_data  = mdi;
      m_owner = -1;
    end else if (m_waited + 1 == TO) begin
      e_val   = 2'(1 << m_owner);
      e_err   = 1;
      e_data  = 0;
      if (e_tcnt != 16'hFFFF) e_tcnt = e_tcnt + 1;
      m_owner = -1;
    end else begin
      m_waited++;
    end
  endtask

  task automatic compare_all();
    check("ctl", {57'd0, gnt, mrd, val, err, busy},
          {57'd0, e_gnt, e_mrd, e_val, e_err, (m_owner >= 0)});
    check("data", {32'd0, data}, {32'd0, e_data});
    check("maddr", {32'd0, maddr}, {32'd0, e_maddr});
    check("counters", {32'd0, tcnt, scnt}, {32'd0, e_tcnt, e_scnt});
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
  endtask

  typedef struct {
    logic [1:0]  rd;
    logic        mdv;
    logic [31:0] mdi;
    logic [1:0]  gnt;
    logic        mrd;
    logic [1:0]  val;
    logic        err;
    logic        busy;
    logic [31:0] data;
  } vec_t;

  vec_t tbl[5];

  initial begin
    int grants;
    logic prev_busy;

    // Single read, response in the third WAIT cycle.
    tbl[0] = '{2'b10, 1'b0, 32'h0,         2'b10, 1'b1, 2'b00, 1'b0, 1'b1, 32'h0};
    tbl[1] = '{2'b00, 1'b0, 32'h0,         2'b00, 1'b0, 2'b00, 1'b0, 1'b1, 32'h0};
    tbl[2] = '{2'b00, 1'b0, 32'h0,         2'b00, 1'b0, 2'b00, 1'b0, 1'b1, 32'h0};
    tbl[3] = '{2'b00, 1'b1, 32'hCAFE_0001, 2'b00, 1'b0, 2'b10, 1'b0, 1'b0, 32'hCAFE_0001};
    tbl[4] = '{2'b00, 1'b0, 32'h0,         2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 32'h0};

    rst_n    = 1'b1;
    req_rd   = 2'b00;
    req_addr = {32'h0000_1040, 32'h0000_2000};
    mdv      = 1'b0;
    mdi      = 32'h0;
    model_reset();

    // Reset asserted asynchronously: outputs clear without a clock edge.
    #2 rst_n = 1'b0;
    #1;
    check("reset_async_zero", {25'd0, gnt, mrd, val, err, busy, tcnt, scnt, maddr[0]},
          64'd0);
    check("reset_async_data", {maddr, data}, 64'd0);
    step();
    rst_n  = 1'b1;
    req_rd = 2'b11;
    step();
    check("reset_first_gnt", {62'd0, gnt}, 64'd1);
    req_rd = 2'b00;
    mdv    = 1'b1;
    mdi    = 32'h1234_5678;
    step();
    mdv = 1'b0;
    step();

    // Single read via vector table.
    for (int i = 0; i < 5; i++) begin
      req_rd = tbl[i].rd;
      mdv    = tbl[i].mdv;
      mdi    = tbl[i].mdi;
      step();
      check($sformatf("single_ctl[%0d]", i), {57'd0, gnt, mrd, val, err, busy},
            {57'd0, tbl[i].gnt, tbl[i].mrd, tbl[i].val, tbl[i].err, tbl[i].busy});
      if (tbl[i].val != 0) check("single_data", {32'd0, data}, {32'd0, tbl[i].data});
      if (tbl[i].mrd) check("single_addr", {32'd0, maddr}, 64'h0000_1040);
    end
    mdv = 1'b0;

    // Round robin with both requesters held high.
    req_rd    = 2'b11;
    grants    = 0;
    prev_busy = busy;
    for (int cyc = 0; cyc < 80 && grants < 6; cyc++) begin
      mdv = (m_owner >= 0) && (m_waited >= 2 || $urandom_range(0, 2) == 0);
      mdi = $urandom;
      step();
      if (gnt != 0) begin
        check("rr_order", {62'd0, gnt}, (grants % 2 == 0) ? 64'd1 : 64'd2);
        check("rr_gnt_while_busy", {63'd0, prev_busy}, 64'd0);
        grants++;
      end
      prev_busy = busy;
    end
    check("rr_grant_count", 64'(grants), 64'd6);
    req_rd = 2'b00;
    for (int cyc = 0; cyc < 10 && m_owner >= 0; cyc++) begin
      mdv = 1'b1;
      step();
    end
    mdv = 1'b0;
    step();

    // Timeout: no response for TO WAIT cycles.
    req_rd = 2'b01;
    step();
    check("to_gnt", {62'd0, gnt}, 64'd1);
    req_rd = 2'b00;
    for (int i = 0; i < TO - 1; i++) begin
      step();
      check("to_not_early", {62'd0, val}, 64'd0);
    end
    step();
    check("to_val_err", {61'd0, val, err}, {61'd0, 2'b01, 1'b1});
    check("to_data_zero", {32'd0, data}, 64'd0);
    check("to_count", {48'd0, tcnt}, 64'd1);
    step();
    mdv = 1'b1;
    mdi = 32'hDEAD_BEEF;
    step();
    mdv = 1'b0;
    check("late_stray", {48'd0, scnt}, 64'd1);
    check("late_no_val", {62'd0, val}, 64'd0);
    step();

    // Zero-latency response, then response exactly on the timeout cycle.
    req_rd = 2'b10;
    step();
    req_rd = 2'b00;
    mdv    = 1'b1;
    mdi    = 32'h0BAD_F00D;
    step();
    mdv = 1'b0;
    check("zl_val", {61'd0, val, err}, {61'd0, 2'b10, 1'b0});
    check("zl_data", {32'd0, data}, 64'h0BAD_F00D);
    step();
    req_rd = 2'b01;
    step();
    req_rd = 2'b00;
    for (int i = 0; i < TO - 1; i++) step();
    mdv = 1'b1;
    mdi = 32'h5555_AAAA;
    step();
    mdv = 1'b0;
    check("coll_val", {61'd0, val, err}, {61'd0, 2'b01, 1'b0});
    check("coll_data", {32'd0, data}, 64'h5555_AAAA);
    check("coll_tcnt", {48'd0, tcnt}, 64'd1);
    step();

    // Reset while a read is outstanding, response arrives after release.
    req_rd = 2'b01;
    step();
    req_rd = 2'b00;
    step();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check("midwait_reset", {44'd0, busy, val, gnt, tcnt}, 64'd0);
    step();
    rst_n = 1'b1;
    mdv   = 1'b1;
    mdi   = 32'h7777_7777;
    step();
    mdv = 1'b0;
    check("post_reset_no_val", {62'd0, val}, 64'd0);
    check("post_reset_stray", {48'd0, scnt}, 64'd1);
    req_rd = 2'b10;
    step();
    check("post_reset_gnt", {62'd0, gnt}, 64'd2);
    req_rd = 2'b00;
    mdv    = 1'b1;
    step();
    mdv = 1'b0;
    step();

    // Randomised traffic against the reference model.
    for (int cyc = 0; cyc < 400; cyc++) begin
      req_rd   = 2'($urandom_range(0, 3));
      req_addr = {$urandom, $urandom};
      mdv      = ($urandom_range(0, 3) == 0);
      mdi      = $urandom;
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
